// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
package pipeline_pkg;

    localparam int unsigned INS_W            = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface fetch_unit_if;
    import pipeline_pkg::*;

    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [INS_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (pop_i)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, fetch queue, redirect flush/squash.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               deq_ready,
    output logic               ins_valid,
    output logic [INS_W-1:0]   ins,
    output logic [31:0]        ins_pc4,
    output logic [CW-1:0]      fq_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         push, pop, issue;
    logic [CW-1:0] post_cnt;
    logic [INS_W+31:0] head;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        issue      = 1'b0;
        pop        = ins_valid & deq_ready & ~redirect;
        // A live request always has a free slot, so count+1 cannot exceed DEPTH.
        post_cnt   = fq_count + CW'(1) - CW'(pop);
        case (state_q)
            IDLE: begin
                if (redirect)                  fetch_pc_d = redirect_pc;
                else if (fq_count < DEPTH_C)   issue      = 1'b1;
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem.imem_ack ? IDLE : DISCARD;
                end else if (imem.imem_ack) begin
                    push = 1'b1;
                    if (post_cnt < DEPTH_C) issue   = 1'b1;
                    else                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (imem.imem_ack) state_d = IDLE;
                end else if (imem.imem_ack) begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d    = WAIT;
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INS_W + 32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem.imem_rdata, req_addr_q + PC_INC}),
        .rdata_o (head),
        .valid_o (ins_valid),
        .count_o (fq_count)
    );

    assign imem.imem_req  = (state_q != IDLE);
    assign imem.imem_addr = req_addr_q;
    assign ins            = head[INS_W+31:32];
    assign ins_pc4        = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, randomized run vs stream model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          deq_ready;
    logic          ins_valid;
    logic [31:0]   ins;
    logic [31:0]   ins_pc4;
    logic [CW-1:0] fq_count;

    fetch_unit_if imem ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_ready   (deq_ready),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc4     (ins_pc4),
        .fq_count    (fq_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder state for the automatic-ack sequences
    bit          m_pend;
    int          m_cnt;
    int          m_lat_max;
    logic [31:0] m_addr;

    typedef struct {
        logic          ack, deq, rd;
        logic [31:0]   rpc;
        logic          e_req;
        logic [31:0]   e_addr;
        logic          e_valid;
        logic [31:0]   e_ins, e_pc4;
        logic [CW-1:0] e_cnt;
        logic          chk_data;
    } vec_t;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(input logic ack, input logic deq, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ins, input logic [31:0] e_pc4,
                                input logic [CW-1:0] e_cnt, input logic chk_data);
        vec_t v;
        v.ack = ack; v.deq = deq; v.rd = 1'b0; v.rpc = 32'h0;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_ins = e_ins; v.e_pc4 = e_pc4; v.e_cnt = e_cnt; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic deq, input logic rd, input logic [31:0] rpc);
        imem.imem_ack   = ack;
        imem.imem_rdata = ack ? ins_of(imem.imem_addr) : $urandom;
        deq_ready       = deq;
        redirect        = rd;
        redirect_pc     = rd ? rpc : $urandom;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        rst    = 1'b0;
        m_pend = 1'b0;
    endtask

    // Memory answering each request after 1..m_lat_max cycles; also checks address stability.
    task automatic mem_drive(input logic deq, input logic rd, input logic [31:0] rpc);
        logic ack;
        ack = 1'b0;
        if (!imem.imem_req) begin
            m_pend = 1'b0;
        end else begin
            if (!m_pend) begin
                m_pend = 1'b1;
                m_cnt  = (m_lat_max <= 1) ? 0 : $urandom_range(0, m_lat_max - 1);
                m_addr = imem.imem_addr;
            end else begin
                check("addr_stable", imem.imem_addr, m_addr);
            end
            if (m_cnt == 0) begin
                ack    = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        drive(ack, deq, rd, rpc);
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [CW-1:0] cnt);
        check({tag, ".req"},   32'(imem.imem_req), 32'(req));
        if (req) check({tag, ".addr"}, imem.imem_addr, addr);
        check({tag, ".valid"}, 32'(ins_valid), 32'(valid));
        check({tag, ".cnt"},   32'(fq_count), 32'(cnt));
    endtask

    vec_t tbl[6];

    initial begin
        int          acks;
        bit          found;
        int          deqs;
        logic [31:0] exp_next;
        logic        deq, rd;
        logic [31:0] rpc, r;

        // cycle-accurate vectors: reset, 1-cycle memory, deq_ready=1
        tbl[0] = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0, CW'(0), 1'b1);
        tbl[1] = mk(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0, CW'(0), 1'b0);
        tbl[2] = mk(1'b1, 1'b1, 1'b1, 32'h4, 1'b1, ins_of(32'h0), 32'h4, CW'(1), 1'b1);
        tbl[3] = mk(1'b1, 1'b1, 1'b1, 32'h8, 1'b1, ins_of(32'h4), 32'h8, CW'(1), 1'b1);
        tbl[4] = mk(1'b0, 1'b1, 1'b1, 32'hC, 1'b1, ins_of(32'h8), 32'hC, CW'(1), 1'b1);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0,        32'h0, CW'(0), 1'b0);

        do_reset;
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("t1[%0d]", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_cnt);
            if (tbl[i].chk_data) begin
                check($sformatf("t1[%0d].ins", i), ins, tbl[i].e_ins);
                check($sformatf("t1[%0d].pc4", i), ins_pc4, tbl[i].e_pc4);
            end
            drive(tbl[i].ack, tbl[i].deq, tbl[i].rd, tbl[i].rpc);
            tick;
        end

        // queue fills while stalled, then resumes at 0x10
        do_reset;
        m_lat_max = 1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            mem_drive(1'b0, 1'b0, 32'h0);
            if (imem.imem_ack) acks++;
            tick;
        end
        check("t2.acks", 32'(acks), 32'd4);
        check("t2.cnt_full", 32'(fq_count), 32'd4);
        check("t2.req_low", 32'(imem.imem_req), 32'd0);
        check("t2.head_pc4", ins_pc4, 32'h4);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (imem.imem_req) begin
                found = 1'b1;
                check("t2.resume_addr", imem.imem_addr, 32'h10);
            end else begin
                mem_drive(1'b1, 1'b0, 32'h0);
                tick;
            end
        end
        check("t2.resume_seen", 32'(found), 32'd1);

        // redirect while 0x8 outstanding; its ack arrives 3 cycles later and is dropped
        do_reset;
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c1", 1'b1, 32'h0, 1'b0, CW'(0));
        drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c2", 1'b1, 32'h4, 1'b1, CW'(1));
        drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c3", 1'b1, 32'h8, 1'b1, CW'(2));
        drive(1'b0, 1'b0, 1'b1, 32'h100); tick;
        expect_out("t3.c4", 1'b1, 32'h8, 1'b0, CW'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c5", 1'b1, 32'h8, 1'b0, CW'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c6", 1'b1, 32'h8, 1'b0, CW'(0));
        drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c7", 1'b1, 32'h100, 1'b0, CW'(0));
        drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t3.c8", 1'b1, 32'h104, 1'b1, CW'(1));
        check("t3.pc4", ins_pc4, 32'h104);
        check("t3.ins", ins, ins_of(32'h100));

        // redirect coincident with ack and deq_ready
        do_reset;
        drive(1'b0, 1'b1, 1'b0, 32'h0); tick;
        drive(1'b1, 1'b1, 1'b0, 32'h0); tick;
        expect_out("t4.c2", 1'b1, 32'h4, 1'b1, CW'(1));
        drive(1'b1, 1'b1, 1'b1, 32'h200); tick;
        expect_out("t4.c3", 1'b0, 32'h0, 1'b0, CW'(0));
        drive(1'b0, 1'b1, 1'b0, 32'h0); tick;
        expect_out("t4.c4", 1'b1, 32'h200, 1'b0, CW'(0));

        // redirect to the top of the address space: PC+4 wraps to 0
        do_reset;
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); tick;
        expect_out("t5.c1", 1'b0, 32'h0, 1'b0, CW'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t5.c2", 1'b1, 32'hFFFF_FFFC, 1'b0, CW'(0));
        drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        expect_out("t5.c3", 1'b1, 32'h0, 1'b1, CW'(1));
        check("t5.pc4", ins_pc4, 32'h0);
        check("t5.ins", ins, ins_of(32'hFFFF_FFFC));

        // reset mid-transaction with three entries queued
        do_reset;
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0); tick;
        end
        expect_out("t6.pre", 1'b1, 32'hC, 1'b1, CW'(3));
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0); tick;
        check("t6.req",   32'(imem.imem_req), 32'd0);
        check("t6.addr",  imem.imem_addr, 32'h0);
        check("t6.valid", 32'(ins_valid), 32'd0);
        check("t6.ins",   ins, 32'h0);
        check("t6.pc4",   ins_pc4, 32'h0);
        check("t6.cnt",   32'(fq_count), 32'd0);
        rst = 1'b0;
        m_pend = 1'b0;
        tick;
        expect_out("t6.restart", 1'b1, 32'h0, 1'b0, CW'(0));

        // randomized run: delivered stream must be consecutive PCs from the last redirect target
        do_reset;
        m_lat_max = 3;
        exp_next  = 32'h0;
        deqs      = 0;
        for (int c = 0; c < 3000; c++) begin
            deq = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            r   = $urandom;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : {r[31:2], 2'b00};
            check("rnd.valid_vs_cnt", 32'(ins_valid), 32'(fq_count != '0));
            check("rnd.cnt_bound", 32'(fq_count <= CW'(DEPTH)), 32'd1);
            if (ins_valid && deq && !rd) begin
                check("rnd.pc4", ins_pc4, exp_next + 32'd4);
                check("rnd.ins", ins, ins_of(exp_next));
                exp_next = exp_next + 32'd4;
                deqs++;
            end
            if (rd) exp_next = rpc;
            mem_drive(deq, rd, rpc);
            tick;
        end
        check("rnd.progress", 32'(deqs > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
